// File: rtl/seg7_scan_ctrl.sv
// Multi-digit hex display scanner: valid/ready load into a pending register, tear-free
// commit at frame boundaries, active-low segment/digit drive. Optional blink: SEG7_BLINK_EN.
module seg7_scan_ctrl #(
    parameter int N_DIGITS  = 6,
    parameter int SCAN_DIV  = 50000
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_DIV = 25000000
`endif
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_value,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic                  lz_en,
`ifdef SEG7_BLINK_EN
    input  logic [N_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   digit_sel
);

    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_DIGITS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SCAN_DIV - 1);

    logic [4*N_DIGITS-1:0] display;
    logic [4*N_DIGITS-1:0] pending;
    logic                  pend_flag;
    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic                  slot_end;
    logic                  frame_end;
    logic                  accept;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic [N_DIGITS-1:0]   cur_onehot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            4'hF: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign load_ready = ~pend_flag;
    assign accept     = load_valid & ~pend_flag;
    assign slot_end   = (slot_cnt == LAST_SLOT);
    assign frame_end  = slot_end && (scan_idx == LAST_IDX);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot_cnt <= '0;
            scan_idx <= '0;
        end else if (slot_end) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            slot_cnt <= '0;
            scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Accept and commit are mutually exclusive: accept needs pend_flag=0, commit needs pend_flag=1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            display   <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else if (frame_end && pend_flag) begin
            display   <= pending;
            pend_flag <= 1'b0;
        end else if (accept) begin
            pending   <= load_value;
            pend_flag <= 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == LAST_BLINK) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`endif

    // Walk digits from the top so zero_run says whether this digit and all above it are zero.
    always_comb begin
        logic zero_run;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        cur_digit  = 4'h0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        zero_run   = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (display[4*i +: 4] == 4'h0);
            if (scan_idx == IDX_W'(i)) begin
                cur_digit     = display[4*i +: 4];
                cur_blank     = blank_mask[i] || (lz_en && (i != 0) && zero_run);
`ifdef SEG7_BLINK_EN
                cur_blank     = cur_blank || (blink_phase && blink_mask[i]);
`endif
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg       <= 7'h7F;
            digit_sel <= '1;
        end else begin
            seg       <= cur_blank ? 7'h7F : hex_to_seg(cur_digit);
            digit_sel <= ~cur_onehot;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (N_DIGITS=4, SCAN_DIV=4); blink scenario
// is included when SEG7_BLINK_EN is defined.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int SD    = 4;
    localparam int FRAME = N * SD;
`ifdef SEG7_BLINK_EN
    localparam int BD    = 8;
`endif
    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clock      = 1'b0;
    logic        resetn     = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_value = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        lz_en      = 1'b0;
`ifdef SEG7_BLINK_EN
    logic [3:0]  blink_mask = 4'h0;
`endif
    logic [6:0]  seg;
    logic [3:0]  digit_sel;

    // Reference model: edge count since reset release plus the handshake registers.
    int          k;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_flag;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_sel;
    logic        exp_ready;
    int          checks = 0;
    int          errors = 0;

    seg7_scan_ctrl #(
        .N_DIGITS (N),
        .SCAN_DIV (SD)
`ifdef SEG7_BLINK_EN
        ,
        .BLINK_DIV(BD)
`endif
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .blank_mask(blank_mask),
        .lz_en     (lz_en),
`ifdef SEG7_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg       (seg),
        .digit_sel (digit_sel)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        k      = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_flag = 1'b0;
    endtask

    // Predict the outputs after the next edge, advance the model, then clock the DUT.
    task automatic step();
        int          idx;
        logic [15:0] upper;
        logic        blank;
        idx   = (k / SD) % N;
        upper = m_disp >> (4 * idx);
        blank = blank_mask[idx] || (lz_en && idx != 0 && upper == 16'h0);
`ifdef SEG7_BLINK_EN
        if (blink_mask[idx] && ((k / BD) % 2 == 1)) blank = 1'b1;
`endif
        exp_seg = blank ? 7'h7F : DEC[upper[3:0]];
        exp_sel = ~(4'b0001 << idx);
        if (m_flag && ((k + 1) % FRAME == 0)) begin
            m_disp = m_pend;
            m_flag = 1'b0;
        end else if (load_valid && !m_flag) begin
            m_pend = load_value;
            m_flag = 1'b1;
        end
        exp_ready = !m_flag;
        k++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if ({seg, digit_sel, load_ready} !== {7'h7F, 4'hF, 1'b1}) begin
                errors++;
                $display("FAIL reset_hold pass %0d: got seg=%h sel=%h rdy=%b, want seg=7f sel=f rdy=1",
                         pass, seg, digit_sel, load_ready);
            end
            repeat (2) @(posedge clock);
            #1;
        end
        @(negedge clock) resetn = 1'b1;
        model_reset();
        // Commit 0x1234, leave 0x9999 pending, then reset mid-scan.
        for (int c = 0; c < 2 * FRAME + 6; c++) begin
            load_valid = (c == 0) || (c == 2 * FRAME);
            load_value = (c == 0) ? 16'h1234 : 16'h9999;
            step();
            checks++;
            if ({seg, digit_sel, load_ready} !== {exp_seg, exp_sel, exp_ready}) begin
                errors++;
                $display("FAIL reset_pre k=%0d: got seg=%h sel=%h rdy=%b, want seg=%h sel=%h rdy=%b",
                         k, seg, digit_sel, load_ready, exp_seg, exp_sel, exp_ready);
            end
        end
        load_valid = 1'b0;
        resetn     = 1'b0;
        #1;
        checks++;
        if ({seg, digit_sel, load_ready} !== {7'h7F, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got seg=%h sel=%h rdy=%b, want seg=7f sel=f rdy=1",
                     seg, digit_sel, load_ready);
        end
        @(negedge clock) resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            checks++;
            if ({seg, digit_sel, load_ready} !== {exp_seg, exp_sel, exp_ready}) begin
                errors++;
                $display("FAIL reset_post k=%0d: got seg=%h sel=%h rdy=%b, want seg=%h sel=%h rdy=%b",
                         k, seg, digit_sel, load_ready, exp_seg, exp_sel, exp_ready);
            end
        end
    endtask

    // Load 0xA5F0 at a random point mid-frame, then hold load_valid with 0x1111 while pending.
    task automatic test_back_to_back();
        int offset;
        offset = $urandom_range(FRAME - 2, 1);
        for (int c = 0; c < offset + FRAME + 2 + 3 * FRAME; c++) begin
            load_valid = (c >= offset) && (c <= offset + FRAME + 1);
            load_value = (c == offset) ? 16'hA5F0 : 16'h1111;
            step();
            checks++;
            if ({seg, digit_sel, load_ready} !== {exp_seg, exp_sel, exp_ready}) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got seg=%h sel=%h rdy=%b, want seg=%h sel=%h rdy=%b",
                         k, seg, digit_sel, load_ready, exp_seg, exp_sel, exp_ready);
            end
        end
        load_valid = 1'b0;
    endtask

    // Table-driven display scenarios: value, lz_en, blank_mask; each entry runs three frames.
    task automatic test_lz_blank();
        logic [15:0] tbl_val [7] = '{16'h0070, 16'h0070, 16'h0000, 16'h0100, 16'h8888, 16'h8888, 16'h1000};
        logic        tbl_lz  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0]  tbl_bm  [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hF, 4'h1};
        for (int t = 0; t < 7; t++) begin
            lz_en      = tbl_lz[t];
            blank_mask = tbl_bm[t];
            load_value = tbl_val[t];
            for (int c = 0; c < 3 * FRAME; c++) begin
                load_valid = (c == 0);
                step();
                checks++;
                if ({seg, digit_sel, load_ready} !== {exp_seg, exp_sel, exp_ready}) begin
                    errors++;
                    $display("FAIL lz_blank[%0d] k=%0d: got seg=%h sel=%h rdy=%b, want seg=%h sel=%h rdy=%b",
                             t, k, seg, digit_sel, load_ready, exp_seg, exp_sel, exp_ready);
                end
            end
        end
        load_valid = 1'b0;
        lz_en      = 1'b0;
        blank_mask = 4'h0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            load_valid = ($urandom_range(5, 0) == 0);
            load_value = 16'($urandom);
            blank_mask = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0;
            if (c % 16 == 0) lz_en = 1'($urandom);
            if ($urandom_range(7, 0) == 0) load_value[15:8] = 8'h00;
            step();
            checks++;
            if ({seg, digit_sel, load_ready} !== {exp_seg, exp_sel, exp_ready}) begin
                errors++;
                $display("FAIL random k=%0d: got seg=%h sel=%h rdy=%b, want seg=%h sel=%h rdy=%b",
                         k, seg, digit_sel, load_ready, exp_seg, exp_sel, exp_ready);
            end
        end
        load_valid = 1'b0;
        blank_mask = 4'h0;
        lz_en      = 1'b0;
    endtask

`ifdef SEG7_BLINK_EN
    task automatic test_blink();
        blink_mask = 4'b0001;
        load_value = 16'h8888;
        for (int c = 0; c < 6 * FRAME; c++) begin
            load_valid = (c == 0);
            step();
            checks++;
            if ({seg, digit_sel, load_ready} !== {exp_seg, exp_sel, exp_ready}) begin
                errors++;
                $display("FAIL blink k=%0d: got seg=%h sel=%h rdy=%b, want seg=%h sel=%h rdy=%b",
                         k, seg, digit_sel, load_ready, exp_seg, exp_sel, exp_ready);
            end
        end
        load_valid = 1'b0;
        blink_mask = 4'h0;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_lz_blank();
        test_random();
`ifdef SEG7_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
